// File: rtl/sonar_io_bank.sv
// Memory-mapped multi-channel ultrasonic ranger: bus register window plus one
// trigger/echo measurement FSM per channel.
module sonar_io_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned TRIG_CYCLES = 500,
  parameter int unsigned TIMEOUT     = 1900000,
  parameter logic [11:0] BASE_ADDR   = 12'hFF0
) (
  input  logic              clk,
  input  logic              CPU_RESETN,
  input  logic              wEn,
  input  logic [11:0]       addr,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] echo
);

  localparam int unsigned TMAX = (TIMEOUT > TRIG_CYCLES) ? TIMEOUT : TRIG_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT_RISE, MEASURE} state_t;

  logic        hit;
  logic [3:0]  off;
  logic        start_wr;
  logic        stat_wr;
  logic        unused_din;

  assign hit        = (addr[11:4] == BASE_ADDR[11:4]);
  assign off        = addr[3:0];
  assign start_wr   = wEn && hit && (off == 4'd0);
  assign stat_wr    = wEn && hit && (off == 4'd1);
  assign unused_din = ^dataIn;

  logic [NUM_CH-1:0] echo_m, echo_s;

  always_ff @(posedge clk) begin
    if (!CPU_RESETN) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  logic [NUM_CH-1:0] busy_v, done_v, tmo_v;
  logic [CNT_W-1:0]  res_bus [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : ch_g
    state_t           state, state_n;
    logic [TW-1:0]    tmr, tmr_n;
    logic [CNT_W-1:0] width, width_n, result, result_n;
    logic             done, done_n, tmo, tmo_n;

    always_ff @(posedge clk) begin
      if (!CPU_RESETN) begin
        state  <= IDLE;
        tmr    <= '0;
        width  <= '0;
        result <= '0;
        done   <= 1'b0;
        tmo    <= 1'b0;
      end else begin
        state  <= state_n;
        tmr    <= tmr_n;
        width  <= width_n;
        result <= result_n;
        done   <= done_n;
        tmo    <= tmo_n;
      end
    end

    // W1C is applied first so a completion in the same cycle overrides it
    always_comb begin
      state_n  = state;
      tmr_n    = tmr;
      width_n  = width;
      result_n = result;
      done_n   = done;
      tmo_n    = tmo;
      if (stat_wr && dataIn[8+g])  done_n = 1'b0;
      if (stat_wr && dataIn[16+g]) tmo_n  = 1'b0;
      case (state)
        IDLE: begin
          if (start_wr && dataIn[g]) begin
            state_n = TRIG;
            tmr_n   = '0;
            done_n  = 1'b0;
            tmo_n   = 1'b0;
          end
        end
        TRIG: begin
          if (tmr >= TW'(TRIG_CYCLES - 1)) begin
            state_n = WAIT_RISE;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
        WAIT_RISE: begin
          if (echo_s[g]) begin
            state_n = MEASURE;
            width_n = CNT_W'(1);
            tmr_n   = (tmr == '1) ? tmr : tmr + TW'(1);
          end else if (tmr >= TW'(TIMEOUT - 1)) begin
            state_n  = IDLE;
            result_n = '1;
            done_n   = 1'b1;
            tmo_n    = 1'b1;
          end else begin
            tmr_n = tmr + TW'(1);
          end
        end
        MEASURE: begin
          // echo fall is tested before the timer so a coincident fall wins
          if (!echo_s[g]) begin
            state_n  = IDLE;
            result_n = width;
            done_n   = 1'b1;
          end else if (tmr >= TW'(TIMEOUT - 1)) begin
            state_n  = IDLE;
            result_n = '1;
            done_n   = 1'b1;
            tmo_n    = 1'b1;
          end else begin
            width_n = (width == '1) ? width : width + CNT_W'(1);
            tmr_n   = (tmr == '1) ? tmr : tmr + TW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end

    assign trig[g]    = (state == TRIG);
    assign busy_v[g]  = (state != IDLE);
    assign done_v[g]  = done;
    assign tmo_v[g]   = tmo;
    assign res_bus[g] = result;
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (hit) begin
      if (off == 4'd1) begin
        rdata[NUM_CH-1:0]   = busy_v;
        rdata[8 +: NUM_CH]  = done_v;
        rdata[16 +: NUM_CH] = tmo_v;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (off == 4'(i + 2)) rdata[CNT_W-1:0] = res_bus[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!CPU_RESETN) dataOut <= '0;
    else             dataOut <= rdata;
  end

endmodule
